// File: rtl/alu_pipe_if.sv
// Valid/ready stream bundle for alu_pipe: operand/op beats in, result/flag beats out.
// The slave modport is the ALU's view, and the master modport is the producer/consumer view.
interface alu_pipe_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             carry;
    logic             zero;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, out, carry, zero
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, out, carry, zero
    );
endinterface

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with carry/borrow and zero flags and optional saturation.
// Stage 1 holds the accepted operands, and stage 2 holds the registered result.
module alu_pipe #(
    parameter int WIDTH = 16,
    parameter bit SAT   = 1'b0
) (
    input logic       clk,
    input logic       rst_n,
    alu_pipe_if.slave bus
);

    typedef enum logic [2:0] {
        OP_ADD    = 3'b000,
        OP_SUB    = 3'b001,
        OP_INC    = 3'b010,
        OP_DEC    = 3'b011,
        OP_PASS_A = 3'b100,
        OP_PASS_B = 3'b101,
        OP_AND    = 3'b110,
        OP_XOR    = 3'b111
    } op_t;

    logic             s1_valid;
    op_t              s1_op;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic             s2_valid;
    logic             s1_adv;
    logic             s2_adv;

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] res;
    logic             res_carry;

    // A stage may load whenever it is empty or its current beat is leaving.
    assign s2_adv       = !s2_valid || bus.out_ready;
    assign s1_adv       = !s1_valid || s2_adv;
    assign bus.in_ready = s1_adv;
    assign bus.out_valid = s2_valid;

    always_comb begin
        sum       = '0;
        res       = '0;
        res_carry = 1'b0;
        case (s1_op)
            OP_ADD: begin
                sum       = {1'b0, s1_a} + {1'b0, s1_b};
                res       = sum[WIDTH-1:0];
                res_carry = sum[WIDTH];
            end
            OP_SUB: begin
                sum       = {1'b0, s1_a} - {1'b0, s1_b};
                res       = sum[WIDTH-1:0];
                res_carry = (s1_a < s1_b);
            end
            OP_INC: begin
                sum       = {1'b0, s1_a} + (WIDTH+1)'(1);
                res       = sum[WIDTH-1:0];
                res_carry = sum[WIDTH];
            end
            OP_DEC: begin
                sum       = {1'b0, s1_a} - (WIDTH+1)'(1);
                res       = sum[WIDTH-1:0];
                res_carry = (s1_a == '0);
            end
            OP_PASS_A: res = s1_a;
            OP_PASS_B: res = s1_b;
            OP_AND:    res = s1_a & s1_b;
            default:   res = s1_a ^ s1_b;
        endcase

        // Saturation clamps the result, but the carry flag still reports the overflow.
        if (SAT && res_carry) begin
            if (s1_op == OP_ADD || s1_op == OP_INC) begin
                res = '1;
            end else if (s1_op == OP_SUB || s1_op == OP_DEC) begin
                res = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_op    <= OP_ADD;
            s1_a     <= '0;
            s1_b     <= '0;
        end else if (s1_adv) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_op <= op_t'(bus.op);
                s1_a  <= bus.a;
                s1_b  <= bus.b;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid  <= 1'b0;
            bus.out   <= '0;
            bus.carry <= 1'b0;
            bus.zero  <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                bus.out   <= res;
                bus.carry <= res_carry;
                bus.zero  <= (res == '0);
            end
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: three instances (16-bit wrap, 16-bit saturating, 8-bit wrap)
// share one stimulus stream, and each instance is checked against its own expected-result queue.
module tb_alu_pipe;

    localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, INC = 3'd2, DEC = 3'd3;
    localparam logic [2:0] PASS_A = 3'd4, PASS_B = 3'd5, AND_OP = 3'd6, XOR_OP = 3'd7;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_ready;

    int checks   = 0;
    int failures = 0;
    bit rand_done;

    logic [16:0] expq[3][$];
    int          wtab[3] = '{16, 16, 8};
    bit          stab[3] = '{1'b0, 1'b1, 1'b0};
    string       ntab[3] = '{"w16", "w16sat", "w8"};

    alu_pipe_if #(.WIDTH(16)) bus16  ();
    alu_pipe_if #(.WIDTH(16)) bus16s ();
    alu_pipe_if #(.WIDTH(8))  bus8   ();

    assign bus16.in_valid   = in_valid;
    assign bus16.op         = op;
    assign bus16.a          = a;
    assign bus16.b          = b;
    assign bus16.out_ready  = out_ready;
    assign bus16s.in_valid  = in_valid;
    assign bus16s.op        = op;
    assign bus16s.a         = a;
    assign bus16s.b         = b;
    assign bus16s.out_ready = out_ready;
    assign bus8.in_valid    = in_valid;
    assign bus8.op          = op;
    assign bus8.a           = a[7:0];
    assign bus8.b           = b[7:0];
    assign bus8.out_ready   = out_ready;

    alu_pipe #(.WIDTH(16), .SAT(1'b0)) u_w16    (.clk(clk), .rst_n(rst_n), .bus(bus16.slave));
    alu_pipe #(.WIDTH(16), .SAT(1'b1)) u_w16sat (.clk(clk), .rst_n(rst_n), .bus(bus16s.slave));
    alu_pipe #(.WIDTH(8),  .SAT(1'b0)) u_w8     (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Reference: returns {carry, result}, with the result masked to the instance width.
    function automatic logic [16:0] model(input int w, input bit sat, input logic [2:0] f,
                                          input logic [15:0] a_in, input logic [15:0] b_in);
        longint mask, aa, bb, r;
        bit     c;
        mask = (64'd1 << w) - 1;
        aa   = longint'(a_in) & mask;
        bb   = longint'(b_in) & mask;
        c    = 1'b0;
        case (f)
            ADD:     begin r = aa + bb; c = (r > mask); end
            SUB:     begin r = aa - bb; c = (aa < bb);  end
            INC:     begin r = aa + 1;  c = (r > mask); end
            DEC:     begin r = aa - 1;  c = (aa == 0);  end
            PASS_A:  r = aa;
            PASS_B:  r = bb;
            AND_OP:  r = aa & bb;
            default: r = aa ^ bb;
        endcase
        r = r & mask;
        if (sat && c) begin
            if (f == ADD || f == INC) r = mask;
            else if (f == SUB || f == DEC) r = 0;
        end
        return {c, 16'(r)};
    endfunction

    task automatic observe(input int idx, input logic irdy, input logic ovld,
                           input logic [15:0] o, input logic c, input logic z);
        logic [16:0] e;
        if (ovld && out_ready) begin
            if (expq[idx].size() == 0) begin
                checkOutput({ntab[idx], ".pending"}, 32'(expq[idx].size() != 0), 32'd1);
            end else begin
                e = expq[idx].pop_front();
                checkOutput({ntab[idx], ".out"},   32'(o), 32'(e[15:0]));
                checkOutput({ntab[idx], ".carry"}, 32'(c), 32'(e[16]));
                checkOutput({ntab[idx], ".zero"},  32'(z), 32'(e[15:0] == 16'h0));
            end
        end
        if (in_valid && irdy) begin
            expq[idx].push_back(model(wtab[idx], stab[idx], op, a, b));
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            observe(0, bus16.in_ready,  bus16.out_valid,  bus16.out,          bus16.carry,  bus16.zero);
            observe(1, bus16s.in_ready, bus16s.out_valid, bus16s.out,         bus16s.carry, bus16s.zero);
            observe(2, bus8.in_ready,   bus8.out_valid,   {8'h00, bus8.out},  bus8.carry,   bus8.zero);
        end
    end

    // Holds one beat until the 16-bit instance accepts it; called at posedge+1, returns at posedge+1.
    task automatic applyStimulus(input logic [2:0] f, input logic [15:0] av, input logic [15:0] bv);
        bit accepted = 1'b0;
        in_valid = 1'b1;
        op       = f;
        a        = av;
        b        = bv;
        for (int i = 0; i < 100 && !accepted; i++) begin
            @(negedge clk);
            if (bus16.in_ready) accepted = 1'b1;
            @(posedge clk);
            #1;
        end
        if (!accepted) checkOutput("accept_timeout", 32'(accepted), 32'd1);
        in_valid = 1'b0;
        op       = 3'($urandom_range(0, 7));
        a        = 16'($urandom);
        b        = 16'($urandom);
    endtask

    task automatic drainAll();
        int pending;
        out_ready = 1'b1;
        pending   = expq[0].size() + expq[1].size() + expq[2].size();
        for (int i = 0; i < 200 && pending > 0; i++) begin
            @(posedge clk);
            #1;
            pending = expq[0].size() + expq[1].size() + expq[2].size();
        end
        checkOutput("drain_pending", 32'(pending), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        op        = ADD;
        a         = '0;
        b         = '0;
        out_ready = 1'b1;
        rand_done = 1'b0;

        #12;
        checkOutput("rst.out_valid", 32'(bus16.out_valid), 32'd0);
        checkOutput("rst.out",       32'(bus16.out),       32'd0);
        checkOutput("rst.carry",     32'(bus16.carry),     32'd0);
        checkOutput("rst.zero",      32'(bus16.zero),      32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rst.in_ready", 32'(bus16.in_ready), 32'd1);

        $display("[TB] basic add/sub and latency");
        applyStimulus(ADD, 16'h0039, 16'h0030);
        @(negedge clk);
        checkOutput("lat.edge_n",  32'(bus16.out_valid), 32'd0);
        @(negedge clk);
        checkOutput("lat.edge_n1", 32'(bus16.out_valid), 32'd1);
        @(posedge clk);
        #1;
        applyStimulus(SUB, 16'h0039, 16'h0030);
        drainAll();

        $display("[TB] wrap, saturation and 8-bit corner vectors");
        applyStimulus(INC,    16'hFFFF, 16'h1234);
        applyStimulus(DEC,    16'h0000, 16'h0000);
        applyStimulus(ADD,    16'hFFF0, 16'h0020);
        applyStimulus(SUB,    16'h0005, 16'h0009);
        applyStimulus(ADD,    16'h0080, 16'h0080);
        applyStimulus(XOR_OP, 16'h00A5, 16'h00FF);
        applyStimulus(AND_OP, 16'h0F3C, 16'h00F0);
        applyStimulus(PASS_A, 16'hBEEF, 16'h1111);
        applyStimulus(PASS_B, 16'hBEEF, 16'h1111);
        applyStimulus(DEC,    16'h0001, 16'h0000);
        applyStimulus(SUB,    16'h4242, 16'h4242);
        drainAll();

        $display("[TB] backpressure");
        out_ready = 1'b0;
        applyStimulus(ADD, 16'h0001, 16'h0001);
        applyStimulus(ADD, 16'h0002, 16'h0002);
        in_valid = 1'b1;
        op       = ADD;
        a        = 16'h0003;
        b        = 16'h0003;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("bp.in_ready",  32'(bus16.in_ready),  32'd0);
            checkOutput("bp.out_valid", 32'(bus16.out_valid), 32'd1);
            checkOutput("bp.out_held",  32'(bus16.out),       32'h0002);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        applyStimulus(ADD, 16'h0003, 16'h0003);
        drainAll();

        $display("[TB] reset mid-stream");
        out_ready = 1'b0;
        applyStimulus(ADD, 16'h0007, 16'h0008);
        applyStimulus(SUB, 16'h0009, 16'h0001);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("rstmid.out_valid", 32'(bus16.out_valid), 32'd0);
        checkOutput("rstmid.out",       32'(bus16.out),       32'd0);
        checkOutput("rstmid.w8_valid",  32'(bus8.out_valid),  32'd0);
        foreach (expq[i]) expq[i].delete();
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("rstmid.no_stale", 32'(bus16.out_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        applyStimulus(ADD, 16'h1000, 16'h0234);
        drainAll();

        $display("[TB] random stream with random backpressure");
        fork
            begin
                for (int i = 0; i < 80; i++) begin
                    applyStimulus(3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom));
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        drainAll();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
